if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit, 4-bit-opcode CPU; sits directly upstream of the control unit and decode.
- Owns the PC and issues word reads to instruction memory with one request outstanding.
- Buffers one returned instruction if decode stalls.
- Applies branch/jump redirects and flushes wrong-path instructions.
- Presents the opcode to the control unit, forced to a harmless no-op code when the IF/ID register holds no instruction.

Parameters:
PC_W, 16, PC / instruction-memory word-address width
INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
RESET_PC, 0, PC value loaded on reset
NOP_OPCODE, 4'b1111, opcode driven when no valid instruction; decodes to all control outputs 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  one-cycle read request; memory always accepts
imem_addr  out  PC_W  word address of the request; equals pc
imem_rvalid  in  1  read data valid; exactly one per request, 1+ cycles after it
imem_rdata  in  INSTR_W  instruction word
redirect_valid  in  1  branch taken or jump resolved downstream
redirect_pc  in  PC_W  target PC
stall_id  in  1  decode cannot accept; IF/ID holds
if_id_valid  out  1  IF/ID register holds a valid instruction
if_id_instr  out  INSTR_W  fetched instruction
if_id_pc  out  PC_W  address of if_id_instr
if_id_pc_next  out  PC_W  if_id_pc+1, wraps modulo 2^PC_W
opcode  out  4  to control unit; if_id_instr[INSTR_W-1:INSTR_W-4] when if_id_valid, else NOP_OPCODE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=FETCH, pc=RESET_PC, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc=0, hold buffer empty.
  - opcode=NOP_OPCODE.
  - First imem_req asserts the cycle after rst deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc for exactly one cycle, then WAIT.
  - WAIT: imem_req=0; waiting for imem_rvalid.
  - HOLD: a fetched instruction is parked in the hold buffer because IF/ID is occupied and stalled.
  - DISCARD: the response to a redirected-away request is still in flight.
- WAIT with imem_rvalid=1:
  - If !stall_id or !if_id_valid: load IF/ID with {rdata, pc, pc+1}, set if_id_valid=1, pc<=pc+1, go to FETCH.
  - Otherwise: write rdata and pc into the hold buffer, pc<=pc+1, go to HOLD.
- HOLD: when !stall_id, move the hold buffer into IF/ID with valid=1, clear the buffer, go to FETCH. No request is issued in HOLD.
- IF/ID consumed with nothing new (stall_id=0, no load this cycle): if_id_valid<=0. The other IF/ID fields keep their old values.
- stall_id=1: all IF/ID fields hold.
- redirect_valid has priority over everything, including stall_id and a same-cycle rvalid:
  - pc<=redirect_pc; if_id_valid<=0; hold buffer cleared.
  - From WAIT with rvalid=0, go to DISCARD.
  - From WAIT with rvalid=1, drop the data and go to FETCH.
  - From DISCARD with rvalid=0, stay in DISCARD; the pc update still applies.
  - From FETCH, HOLD, or DISCARD with rvalid=1, go to FETCH.
  - In FETCH, the request on that cycle still issues to the old pc, and its response is discarded: the next state is DISCARD, not WAIT.
- DISCARD: on imem_rvalid, drop the data and go to FETCH.
- PC arithmetic: modulo 2^PC_W; 2^PC_W-1 increments to 0.
- Throughput: 1-cycle memory gives one instruction per 2 cycles. imem_rvalid outside WAIT/DISCARD is a protocol error and is ignored.

Optional Feature:
- Macro: IF_STAGE_PERF_EN.
- When defined, two extra output ports are added:
  - perf_fetch_cnt (32b): increments on every instruction loaded into IF/ID.
  - perf_flush_cnt (32b): increments on every cycle with redirect_valid=1.
  - Both reset to 0 on rst and wrap at 2^32.
- When undefined, the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset, memory returns rdata=16'h1234 one cycle after each request -> imem_addr sequence 0,1,2; if_id_pc 0 then 1; opcode 4'h1 once if_id_valid=1; opcode 4'hF while if_id_valid=0.
- stall_id held high for 4 cycles while the instruction at pc=1 returns and if_id holds pc=0 -> state HOLD, no imem_req, if_id holds pc=0. Cycle after stall drops: if_id_pc=1, valid=1. Next request is addr 2.
- redirect_valid=1 with redirect_pc=16'h0040 while WAIT (memory latency 3) -> if_id_valid=0. The late response is dropped (never appears in IF/ID). Next imem_addr=16'h0040.
- redirect_valid and stall_id both 1, with IF/ID valid and hold buffer full -> both cleared next cycle; opcode=4'hF; fetch resumes at redirect_pc.
- RESET_PC=16'hFFFF -> fetch addresses FFFF then 0000; if_id_pc_next=0000 for the instruction at FFFF.
- rst asserted for one cycle during WAIT -> all outputs at reset values next cycle. The stale rvalid arriving in FETCH is ignored. With IF_STAGE_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID pipeline register: owns the PC, issues one
// outstanding imem read, parks one instruction on a decode stall, and flushes
// wrong-path instructions on a redirect. Define IF_STAGE_PERF_EN to add the
// perf_fetch_cnt / perf_flush_cnt counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_FETCH   | issue imem_req at pc (only once armed after reset)
//   S_WAIT    | request outstanding, waiting for imem_rvalid
//   S_HOLD    | fetched instruction parked, IF/ID occupied and stalled
//   S_DISCARD | response to a redirected-away request still in flight
module if_stage #(
  parameter int               PC_W       = 16,
  parameter int               INSTR_W    = 16,
  parameter logic [PC_W-1:0]  RESET_PC   = '0,
  parameter logic [3:0]       NOP_OPCODE = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall_id,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_next,
  output logic [3:0]         opcode
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_armed;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic                r_if_id_valid;
  logic [INSTR_W-1:0]  r_if_id_instr;
  logic [PC_W-1:0]     r_if_id_pc;
  logic                r_hold_valid;
  logic [INSTR_W-1:0]  r_hold_instr;
  logic [PC_W-1:0]     r_hold_pc;

  logic w_fetch_issue;
  logic w_accept;
  logic w_rsp;
  logic w_load_mem;
  logic w_park;
  logic w_load_hold;

  // r_armed delays the first request by one cycle so imem_req reads 0 right after reset
  assign w_fetch_issue = (r_state == S_FETCH) && r_armed;
  assign w_accept      = !stall_id || !r_if_id_valid;
  assign w_rsp         = (r_state == S_WAIT) && imem_rvalid;
  assign w_load_mem    = w_rsp && w_accept && !redirect_valid;
  assign w_park        = w_rsp && !w_accept && !redirect_valid;
  assign w_load_hold   = (r_state == S_HOLD) && r_hold_valid && !stall_id && !redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_FETCH:   if (r_armed) w_state_nxt = S_WAIT;
      S_WAIT:    if (imem_rvalid) w_state_nxt = w_accept ? S_FETCH : S_HOLD;
      S_HOLD:    if (!stall_id) w_state_nxt = S_FETCH;
      S_DISCARD: if (imem_rvalid) w_state_nxt = S_FETCH;
      default:   w_state_nxt = S_FETCH;
    endcase
    if (w_rsp) w_pc_nxt = r_pc + PC_ONE;
    // A redirect still leaves a response in flight if a request was just issued or not yet answered
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
      if (w_fetch_issue ||
          (((r_state == S_WAIT) || (r_state == S_DISCARD)) && !imem_rvalid))
        w_state_nxt = S_DISCARD;
      else
        w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_armed       <= 1'b0;
      r_pc          <= RESET_PC;
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= '0;
      r_if_id_pc    <= '0;
      r_hold_valid  <= 1'b0;
      r_hold_instr  <= '0;
      r_hold_pc     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      r_pc    <= w_pc_nxt;
      if (redirect_valid) begin
        r_if_id_valid <= 1'b0;
        r_hold_valid  <= 1'b0;
      end else if (w_load_mem) begin
        r_if_id_valid <= 1'b1;
        r_if_id_instr <= imem_rdata;
        r_if_id_pc    <= r_pc;
      end else if (w_load_hold) begin
        r_if_id_valid <= 1'b1;
        r_if_id_instr <= r_hold_instr;
        r_if_id_pc    <= r_hold_pc;
        r_hold_valid  <= 1'b0;
      end else if (!stall_id) begin
        r_if_id_valid <= 1'b0;
      end
      if (w_park) begin
        r_hold_valid <= 1'b1;
        r_hold_instr <= imem_rdata;
        r_hold_pc    <= r_pc;
      end
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_load_mem || w_load_hold) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (redirect_valid)            r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

  assign imem_req      = w_fetch_issue;
  assign imem_addr     = r_pc;
  assign if_id_valid   = r_if_id_valid;
  assign if_id_instr   = r_if_id_instr;
  assign if_id_pc      = r_if_id_pc;
  assign if_id_pc_next = r_if_id_pc + PC_ONE;
  assign opcode        = r_if_id_valid ? r_if_id_instr[INSTR_W-1 -: 4] : NOP_OPCODE;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: main instance (RESET_PC=0) with variable memory
// latency, plus a RESET_PC=16'hFFFF instance checking PC wrap.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_id;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        tie0 = 1'b0;
  logic [15:0] tie0_16 = 16'h0000;

  logic [1:0]        m_req;
  logic [1:0][15:0]  m_addr;
  logic [1:0]        m_rvalid = '0;
  logic [1:0][15:0]  m_rdata  = '0;
  logic [1:0]        m_pend   = '0;
  logic [1:0][15:0]  m_lat_addr = '0;
  int                m_cnt [2];
  int                lat;

  logic [1:0]        if_id_valid;
  logic [1:0][15:0]  if_id_instr;
  logic [1:0][15:0]  if_id_pc;
  logic [1:0][15:0]  if_id_pc_next;
  logic [1:0][3:0]   opcode;
`ifdef IF_STAGE_PERF_EN
  logic [1:0][31:0]  perf_fetch_cnt;
  logic [1:0][31:0]  perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  if_stage #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(m_req[0]), .imem_addr(m_addr[0]),
    .imem_rvalid(m_rvalid[0]), .imem_rdata(m_rdata[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_id(stall_id),
    .if_id_valid(if_id_valid[0]), .if_id_instr(if_id_instr[0]),
    .if_id_pc(if_id_pc[0]), .if_id_pc_next(if_id_pc_next[0]),
    .opcode(opcode[0])
`ifdef IF_STAGE_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt[0]), .perf_flush_cnt(perf_flush_cnt[0])
`endif
  );

  if_stage #(.RESET_PC(16'hFFFF)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(m_req[1]), .imem_addr(m_addr[1]),
    .imem_rvalid(m_rvalid[1]), .imem_rdata(m_rdata[1]),
    .redirect_valid(tie0), .redirect_pc(tie0_16),
    .stall_id(tie0),
    .if_id_valid(if_id_valid[1]), .if_id_instr(if_id_instr[1]),
    .if_id_pc(if_id_pc[1]), .if_id_pc_next(if_id_pc_next[1]),
    .opcode(opcode[1])
`ifdef IF_STAGE_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt[1]), .perf_flush_cnt(perf_flush_cnt[1])
`endif
  );

  // memory: answers each request 'lat' cycles later (wrap instance: 1 cycle);
  // data = 16'h1234 + {addr[3:0], 12'h000}
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_rvalid[k] = 1'b0;
      if (m_pend[k]) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          m_rvalid[k] = 1'b1;
          m_rdata[k]  = 16'h1234 + {m_lat_addr[k][3:0], 12'h000};
          m_pend[k]   = 1'b0;
        end
      end
      if (m_req[k]) begin
        m_pend[k]     = 1'b1;
        m_lat_addr[k] = m_addr[k];
        m_cnt[k]      = (k == 0) ? lat : 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; lat = 1;
    step(); step();                                   // t=20
    chk("rst_valid",   32'(if_id_valid[0]), 32'h0);
    chk("rst_opcode",  32'(opcode[0]),      32'hF);
    chk("rst_req",     32'(m_req[0]),       32'h0);
    chk("rst_addr",    32'(m_addr[0]),      32'h0000);
    chk("rst_ifpc",    32'(if_id_pc[0]),    32'h0000);
    chk("rst_instr",   32'(if_id_instr[0]), 32'h0000);
    chk("wrap_rst_addr", 32'(m_addr[1]),    32'hFFFF);
    rst = 1'b0;
    step();                                           // t=30
    chk("f0_req",  32'(m_req[0]),  32'h1);
    chk("f0_addr", 32'(m_addr[0]), 32'h0000);
    chk("wrap_f0_addr", 32'(m_addr[1]), 32'hFFFF);
    step();                                           // t=40
    chk("w0_req",    32'(m_req[0]),       32'h0);
    chk("w0_opcode", 32'(opcode[0]),      32'hF);
    step();                                           // t=50
    chk("l0_valid",  32'(if_id_valid[0]),   32'h1);
    chk("l0_pc",     32'(if_id_pc[0]),      32'h0000);
    chk("l0_instr",  32'(if_id_instr[0]),   32'h1234);
    chk("l0_opcode", 32'(opcode[0]),        32'h1);
    chk("l0_pcnext", 32'(if_id_pc_next[0]), 32'h0001);
    chk("f1_addr",   32'(m_addr[0]),        32'h0001);
    chk("wrap_l_pc",     32'(if_id_pc[1]),      32'hFFFF);
    chk("wrap_l_pcnext", 32'(if_id_pc_next[1]), 32'h0000);
    chk("wrap_f1_addr",  32'(m_addr[1]),        32'h0000);
    chk("wrap_f1_req",   32'(m_req[1]),         32'h1);
`ifdef IF_STAGE_PERF_EN
    chk("perf_fetch_1", perf_fetch_cnt[0], 32'd1);
`endif
    stall_id = 1'b1;
    step(); step();                                   // t=70, instr@1 parked
    chk("hold_req",   32'(m_req[0]),       32'h0);
    chk("hold_valid", 32'(if_id_valid[0]), 32'h1);
    chk("hold_pc",    32'(if_id_pc[0]),    32'h0000);
    step();                                           // t=80
    chk("hold2_req",  32'(m_req[0]),       32'h0);
    chk("hold2_pc",   32'(if_id_pc[0]),    32'h0000);
    step();                                           // t=90
    stall_id = 1'b0; lat = 3;
    step();                                           // t=100
    chk("unhold_valid",  32'(if_id_valid[0]), 32'h1);
    chk("unhold_pc",     32'(if_id_pc[0]),    32'h0001);
    chk("unhold_instr",  32'(if_id_instr[0]), 32'h2234);
    chk("unhold_opcode", 32'(opcode[0]),      32'h2);
    chk("f2_addr",       32'(m_addr[0]),      32'h0002);
    chk("f2_req",        32'(m_req[0]),       32'h1);
    stall_id = 1'b1;
    step();                                           // t=110, in WAIT
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();                                           // t=120
    redirect_valid = 1'b0; stall_id = 1'b0;
    chk("redir_valid",  32'(if_id_valid[0]), 32'h0);
    chk("redir_opcode", 32'(opcode[0]),      32'hF);
    chk("redir_req",    32'(m_req[0]),       32'h0);
    step(); step();                                   // t=140, stale rsp dropped
    chk("redir_f_req",   32'(m_req[0]),       32'h1);
    chk("redir_f_addr",  32'(m_addr[0]),      32'h0040);
    chk("drop_valid",    32'(if_id_valid[0]), 32'h0);
    step();                                           // t=150
    lat = 1;
    chk("drop2_valid",   32'(if_id_valid[0]), 32'h0);
    step(); step(); step();                           // t=180
    chk("t40_valid", 32'(if_id_valid[0]), 32'h1);
    chk("t40_pc",    32'(if_id_pc[0]),    32'h0040);
    chk("t40_instr", 32'(if_id_instr[0]), 32'h1234);
    stall_id = 1'b1;
    step(); step();                                   // t=200, HOLD with buffer full
    chk("h41_req",   32'(m_req[0]),       32'h0);
    chk("h41_valid", 32'(if_id_valid[0]), 32'h1);
    chk("h41_pc",    32'(if_id_pc[0]),    32'h0040);
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    step();                                           // t=210
    redirect_valid = 1'b0; stall_id = 1'b0;
    chk("rs_valid",  32'(if_id_valid[0]), 32'h0);
    chk("rs_opcode", 32'(opcode[0]),      32'hF);
    chk("rs_req",    32'(m_req[0]),       32'h1);
    chk("rs_addr",   32'(m_addr[0]),      32'h0080);
    step();                                           // t=220
    lat = 2;
    step();                                           // t=230
    chk("t80_valid",  32'(if_id_valid[0]),   32'h1);
    chk("t80_pc",     32'(if_id_pc[0]),      32'h0080);
    chk("t80_pcnext", 32'(if_id_pc_next[0]), 32'h0081);
    chk("t80_instr",  32'(if_id_instr[0]),   32'h1234);
`ifdef IF_STAGE_PERF_EN
    chk("perf_fetch_4", perf_fetch_cnt[0], 32'd4);
    chk("perf_flush_2", perf_flush_cnt[0], 32'd2);
`endif
    step();                                           // t=240, WAIT on addr 0x81
    rst = 1'b1;
    step();                                           // t=250
    rst = 1'b0;
    chk("rst2_valid",  32'(if_id_valid[0]),   32'h0);
    chk("rst2_opcode", 32'(opcode[0]),        32'hF);
    chk("rst2_req",    32'(m_req[0]),         32'h0);
    chk("rst2_addr",   32'(m_addr[0]),        32'h0000);
    chk("rst2_ifpc",   32'(if_id_pc[0]),      32'h0000);
    chk("rst2_instr",  32'(if_id_instr[0]),   32'h0000);
    chk("rst2_pcnext", 32'(if_id_pc_next[0]), 32'h0001);
`ifdef IF_STAGE_PERF_EN
    chk("rst2_perf_fetch", perf_fetch_cnt[0], 32'd0);
    chk("rst2_perf_flush", perf_flush_cnt[0], 32'd0);
`endif
    step();                                           // t=260, stale rvalid ignored
    chk("rst2_f_req",   32'(m_req[0]),       32'h1);
    chk("rst2_f_addr",  32'(m_addr[0]),      32'h0000);
    chk("rst2_f_valid", 32'(if_id_valid[0]), 32'h0);
    step(); step(); step();                           // t=290
    chk("rst2_l_valid", 32'(if_id_valid[0]), 32'h1);
    chk("rst2_l_pc",    32'(if_id_pc[0]),    32'h0000);
    chk("rst2_l_instr", 32'(if_id_instr[0]), 32'h1234);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
